armleocpu_mem_arbiter: RTL and testbench

Two-master Avalon-MM arbiter that shares the single core memory port between the page table walker (master 0, read-only) and the cache/load-store unit (master 1, read/write). It sits between those masters and the bus. It serialises single-beat transactions with round-robin priority and routes read responses back only to the owning master.

---
 rtl/armleocpu_mem_arbiter.sv | 117 +++++++++++
 tb/tb_armleocpu_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/armleocpu_mem_arbiter.sv
// Two-master Avalon-MM arbiter: PTW (m0, read-only) and cache (m1) share one bus port.
// Single-beat transactions, round-robin on ties, read data valid routed to the owner only.
module armleocpu_mem_arbiter (
    input  logic        clk,
    input  logic        async_rst_n,

    input  logic [33:0] m0_address,
    input  logic        m0_read,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    output logic        m0_readdatavalid,
    output logic [1:0]  m0_response,

    input  logic [33:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic        m1_readdatavalid,
    output logic [1:0]  m1_response,

    output logic [33:0] avl_address,
    output logic        avl_read,
    output logic        avl_write,
    output logic [31:0] avl_writedata,
    output logic [3:0]  avl_byteenable,
    input  logic        avl_waitrequest,
    input  logic [31:0] avl_readdata,
    input  logic        avl_readdatavalid,
    input  logic [1:0]  avl_response
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   owner;
    logic   last;

    logic   req0, req1, any_req, winner;
    logic   sel_read, sel_write;
    logic   rdv_window;

    assign req0    = m0_read;
    assign req1    = m1_read | m1_write;
    assign any_req = req0 | req1;
    // On a tie the master that did not win last time goes next.
    assign winner  = (req0 && req1) ? ~last : req1;

    // m1 read+write together is illegal; it is treated as a read.
    assign sel_read  = owner ? m1_read : m0_read;
    assign sel_write = owner ? (m1_write & ~m1_read) : 1'b0;

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                owner <= winner;
                last  <= winner;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_req)
                    state_nxt = CMD;
            end
            CMD: begin
                if (!avl_waitrequest) begin
                    if (sel_read && !avl_readdatavalid)
                        state_nxt = RESP;
                    else
                        state_nxt = IDLE;
                end
            end
            RESP: begin
                if (avl_readdatavalid)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address/data follow the owner continuously; only the command strobes are gated by state.
    assign avl_address    = owner ? m1_address : m0_address;
    assign avl_writedata  = owner ? m1_writedata : 32'h0;
    assign avl_byteenable = owner ? m1_byteenable : 4'hF;
    assign avl_read       = (state == CMD) && sel_read;
    assign avl_write      = (state == CMD) && sel_write;

    assign m0_waitrequest = !((state == CMD) && !owner) || avl_waitrequest;
    assign m1_waitrequest = !((state == CMD) &&  owner) || avl_waitrequest;

    // Data valid is only trusted once a read has been accepted; stale beats in IDLE are dropped.
    assign rdv_window = ((state == CMD) && sel_read && !avl_waitrequest) || (state == RESP);

    assign m0_readdatavalid = rdv_window && !owner && avl_readdatavalid;
    assign m1_readdatavalid = rdv_window &&  owner && avl_readdatavalid;

    assign m0_readdata = avl_readdata;
    assign m1_readdata = avl_readdata;
    assign m0_response = avl_response;
    assign m1_response = avl_response;

endmodule

// File: tb/tb_armleocpu_mem_arbiter.sv
// Directed bench for armleocpu_mem_arbiter: single reads/writes, arbitration order,
// delayed responses, reset mid-transaction and the illegal m1 read+write case.
module tb_armleocpu_mem_arbiter;

    logic        clk;
    logic        async_rst_n;
    logic [33:0] m0_address;
    logic        m0_read;
    logic        m0_waitrequest;
    logic [31:0] m0_readdata;
    logic        m0_readdatavalid;
    logic [1:0]  m0_response;
    logic [33:0] m1_address;
    logic        m1_read;
    logic        m1_write;
    logic [31:0] m1_writedata;
    logic [3:0]  m1_byteenable;
    logic        m1_waitrequest;
    logic [31:0] m1_readdata;
    logic        m1_readdatavalid;
    logic [1:0]  m1_response;
    logic [33:0] avl_address;
    logic        avl_read;
    logic        avl_write;
    logic [31:0] avl_writedata;
    logic [3:0]  avl_byteenable;
    logic        avl_waitrequest;
    logic [31:0] avl_readdata;
    logic        avl_readdatavalid;
    logic [1:0]  avl_response;

    int n_checks = 0;
    int n_fail   = 0;

    armleocpu_mem_arbiter dut (
        .clk(clk), .async_rst_n(async_rst_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid), .m0_response(m0_response),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid), .m1_response(m1_response),
        .avl_address(avl_address), .avl_read(avl_read), .avl_write(avl_write),
        .avl_writedata(avl_writedata), .avl_byteenable(avl_byteenable),
        .avl_waitrequest(avl_waitrequest), .avl_readdata(avl_readdata),
        .avl_readdatavalid(avl_readdatavalid), .avl_response(avl_response)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then driven, and checks follow #1 later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_avl_read"},  avl_read, 1'b0);
        check({tag, "_avl_write"}, avl_write, 1'b0);
        check({tag, "_m0_wait"},   m0_waitrequest, 1'b1);
        check({tag, "_m1_wait"},   m1_waitrequest, 1'b1);
        check({tag, "_m0_rdv"},    m0_readdatavalid, 1'b0);
        check({tag, "_m1_rdv"},    m1_readdatavalid, 1'b0);
    endtask

    task automatic do_reset();
        async_rst_n = 1'b0;
        step();
        step();
        async_rst_n = 1'b1;
    endtask

    initial begin
        async_rst_n       = 1'b1;
        m0_address        = '0;
        m0_read           = 1'b0;
        m1_address        = '0;
        m1_read           = 1'b0;
        m1_write          = 1'b0;
        m1_writedata      = '0;
        m1_byteenable     = '0;
        avl_waitrequest   = 1'b0;
        avl_readdata      = '0;
        avl_readdatavalid = 1'b0;
        avl_response      = 2'b00;
        #3;
        async_rst_n = 1'b0;
        #1;
        check_reset_outputs("por");
        step();
        async_rst_n = 1'b1;

        // Single m0 read, data in the accept cycle
        step();
        m0_read    = 1'b1;
        m0_address = 34'h0_0000_1000;
        #1;
        check("t1_idle_avl_read", avl_read, 1'b0);
        step();
        avl_waitrequest   = 1'b0;
        avl_readdatavalid = 1'b1;
        avl_readdata      = 32'hDEADBEEF;
        #1;
        check("t1_avl_read", avl_read, 1'b1);
        check("t1_avl_addr", avl_address, 34'h0_0000_1000);
        check("t1_avl_be", avl_byteenable, 4'hF);
        check("t1_avl_write", avl_write, 1'b0);
        check("t1_m0_wait", m0_waitrequest, 1'b0);
        check("t1_m0_rdv", m0_readdatavalid, 1'b1);
        check("t1_m0_data", m0_readdata, 32'hDEADBEEF);
        check("t1_m1_rdv", m1_readdatavalid, 1'b0);
        check("t1_m1_wait", m1_waitrequest, 1'b1);
        step();
        m0_read = 1'b0;
        #1;
        check("t1_back_idle_avl_read", avl_read, 1'b0);
        check("t1_stale_rdv_m0", m0_readdatavalid, 1'b0);
        avl_readdatavalid = 1'b0;

        // m1 write with 3 waitrequest cycles
        m1_write        = 1'b1;
        m1_address      = 34'h0_0000_0004;
        m1_writedata    = 32'h12345678;
        m1_byteenable   = 4'b0011;
        avl_waitrequest = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            avl_waitrequest = (i < 3);
            #1;
            check($sformatf("t2_avl_write_%0d", i), avl_write, 1'b1);
            check($sformatf("t2_wdata_%0d", i), avl_writedata, 32'h12345678);
            check($sformatf("t2_be_%0d", i), avl_byteenable, 4'b0011);
            check($sformatf("t2_addr_%0d", i), avl_address, 34'h4);
            check($sformatf("t2_m1_wait_%0d", i), m1_waitrequest, (i < 3));
            check($sformatf("t2_m0_wait_%0d", i), m0_waitrequest, 1'b1);
            step();
        end
        m1_write = 1'b0;
        #1;
        check("t2_idle_avl_write", avl_write, 1'b0);
        check("t2_idle_m1_wait", m1_waitrequest, 1'b1);

        // Simultaneous requests after reset: m0 first, then strict alternation
        do_reset();
        m0_address        = 34'h2_0000_0100;
        m1_address        = 34'h0_0000_0200;
        m0_read           = 1'b1;
        m1_read           = 1'b1;
        avl_waitrequest   = 1'b0;
        avl_readdatavalid = 1'b1;
        avl_readdata      = 32'hA5A5_0001;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("t3_idle_read_%0d", k), avl_read, 1'b0);
            check($sformatf("t3_idle_rdv0_%0d", k), m0_readdatavalid, 1'b0);
            check($sformatf("t3_idle_rdv1_%0d", k), m1_readdatavalid, 1'b0);
            step();
            #1;
            check($sformatf("t3_addr_%0d", k), avl_address, (k % 2 == 0) ? 34'h2_0000_0100 : 34'h0_0000_0200);
            check($sformatf("t3_m0_wait_%0d", k), m0_waitrequest, (k % 2 == 0) ? 1'b0 : 1'b1);
            check($sformatf("t3_m1_wait_%0d", k), m1_waitrequest, (k % 2 == 0) ? 1'b1 : 1'b0);
            check($sformatf("t3_m0_rdv_%0d", k), m0_readdatavalid, (k % 2 == 0));
            check($sformatf("t3_m1_rdv_%0d", k), m1_readdatavalid, (k % 2 == 1));
            step();
        end
        // Last grant went to m1; with only m1 requesting now m1 wins again.
        m0_read           = 1'b0;
        avl_readdatavalid = 1'b0;

        // Delayed read response on m1 with an error code, m0 waiting behind it
        step();
        #1;
        check("t4_cmd_m1_wait", m1_waitrequest, 1'b0);
        check("t4_cmd_m1_rdv", m1_readdatavalid, 1'b0);
        check("t4_cmd_avl_read", avl_read, 1'b1);
        step();
        m1_read = 1'b0;
        m0_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("t4_resp_read_%0d", i), avl_read, 1'b0);
            check($sformatf("t4_resp_m0_wait_%0d", i), m0_waitrequest, 1'b1);
            check($sformatf("t4_resp_m1_rdv_%0d", i), m1_readdatavalid, 1'b0);
            step();
        end
        avl_readdatavalid = 1'b1;
        avl_response      = 2'b10;
        avl_readdata      = 32'hC0FF_EE00;
        #1;
        check("t4_m1_rdv", m1_readdatavalid, 1'b1);
        check("t4_m1_resp", m1_response, 2'b10);
        check("t4_m1_data", m1_readdata, 32'hC0FF_EE00);
        check("t4_m0_rdv", m0_readdatavalid, 1'b0);
        step();
        avl_readdatavalid = 1'b0;
        avl_response      = 2'b00;
        #1;
        check("t4_idle_read", avl_read, 1'b0);
        step();
        avl_readdatavalid = 1'b1;
        #1;
        check("t4_m0_granted", avl_read, 1'b1);
        check("t4_m0_addr", avl_address, 34'h2_0000_0100);
        check("t4_m0_wait", m0_waitrequest, 1'b0);
        check("t4_m0_rdv_after", m0_readdatavalid, 1'b1);
        step();
        m0_read           = 1'b0;
        avl_readdatavalid = 1'b0;

        // Reset while waiting for read data, then a stray readdatavalid
        m1_read = 1'b1;
        step();
        step();
        m1_read = 1'b0;
        #1;
        check("t5_in_resp_m1_wait", m1_waitrequest, 1'b1);
        async_rst_n = 1'b0;
        #1;
        check_reset_outputs("t5_rst");
        step();
        step();
        async_rst_n       = 1'b1;
        avl_readdatavalid = 1'b1;
        #1;
        check("t5_stray_m0_rdv", m0_readdatavalid, 1'b0);
        check("t5_stray_m1_rdv", m1_readdatavalid, 1'b0);
        step();
        #1;
        check("t5_stray2_m1_rdv", m1_readdatavalid, 1'b0);
        check("t5_stray2_avl_read", avl_read, 1'b0);
        avl_readdatavalid = 1'b0;

        // Illegal m1 read+write is treated as a read
        m1_read    = 1'b1;
        m1_write   = 1'b1;
        m1_address = 34'h0_0000_0040;
        step();
        avl_readdatavalid = 1'b1;
        #1;
        check("t6_avl_read", avl_read, 1'b1);
        check("t6_avl_write", avl_write, 1'b0);
        check("t6_m1_rdv", m1_readdatavalid, 1'b1);
        step();
        m1_read           = 1'b0;
        m1_write          = 1'b0;
        avl_readdatavalid = 1'b0;
        #1;
        check("t6_idle_read", avl_read, 1'b0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
